output_module: RTL and testbench

OUTPUT_MODULE -- requirements
Module: output_module

---
 rtl/output_module.sv | 115 +++++++++++
 tb/tb_output_module.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_module.sv
// Router output port: round-robin arbitration among the input VCs feeding a
// small FIFO that drives the downstream link, with occupancy and transmit counters.
module output_module #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 5,
   parameter int OUT_DEPTH  = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_packet,
   input  logic [NUM_INPUTS-1:0]            in_valid,
   output logic [NUM_INPUTS-1:0]            in_ready,
   output logic [DATA_WIDTH-1:0]            out_packet,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [$clog2(OUT_DEPTH):0]       occupancy,
   output logic [15:0]                      tx_count
);

   // Handshake: a transfer happens on a rising edge exactly when valid and
   // ready are both high in the cycle before it; valid never waits on ready,
   // and a stalled out_valid/out_packet holds until it is taken.

   localparam int PTR_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int SUM_W  = PTR_W + 1;
   localparam int ADDR_W = $clog2(OUT_DEPTH);
   localparam int OCC_W  = ADDR_W + 1;

   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      grant_idx;
   logic [PTR_W-1:0]      cand;
   logic [SUM_W-1:0]      sum;
   logic                  found;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] push_data;
   logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
   logic [ADDR_W-1:0]     rd_ptr;
   logic [ADDR_W-1:0]     wr_ptr;

   assign full = (occupancy == OCC_W'(OUT_DEPTH));

   // Search ptr, ptr+1, ... modulo NUM_INPUTS for the first requester.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      sum       = '0;
      cand      = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         sum = {1'b0, ptr} + SUM_W'(k);
         if (sum >= SUM_W'(NUM_INPUTS)) begin
            sum = sum - SUM_W'(NUM_INPUTS);
         end
         cand = sum[PTR_W-1:0];
         if (!found && in_valid[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // No grant while full, even if the head is leaving this cycle.
   always_comb begin
      in_ready = '0;
      if (found && !full && !rst) begin
         in_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      push_data = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (in_ready[i]) begin
            push_data = in_packet[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign push       = |in_ready;
   assign out_valid  = (occupancy != '0);
   assign pop        = out_valid && out_ready;
   assign out_packet = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
         tx_count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            ptr    <= (grant_idx == PTR_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + ADDR_W'(1);
            tx_count <= tx_count + 16'd1;
         end
         case ({push, pop})
            2'b10:   occupancy <= occupancy + OCC_W'(1);
            2'b01:   occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

endmodule

// File: tb/tb_output_module.sv
// Self-checking bench for output_module: directed scenarios plus a randomized
// arbitration run, with a packet scoreboard on the output side.
module tb_output_module;

   localparam int DW = 32;
   localparam int NI = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NI*DW-1:0] in_packet = '0;
   logic [NI-1:0]   in_valid = '0;
   logic [NI-1:0]   in_ready;
   logic [DW-1:0]   out_packet;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [2:0]      occupancy;
   logic [15:0]     tx_count;

   logic [DW-1:0]   exp_q[$];
   logic [DW-1:0]   pkts [NI];
   int              checks = 0;
   int              errors = 0;

   output_module #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .OUT_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_packet(in_packet), .in_valid(in_valid),
      .in_ready(in_ready), .out_packet(out_packet), .out_valid(out_valid),
      .out_ready(out_ready), .occupancy(occupancy), .tx_count(tx_count)
   );

   always #5 clk = ~clk;

   // Output-side scoreboard: every handshake must deliver the oldest expected packet.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_pop: got %h, expected no packet", out_packet);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (out_packet !== e) begin
               errors++;
               $display("FAIL scoreboard_pop: got %h, expected %h", out_packet, e);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pack_pkts;
      for (int i = 0; i < NI; i++) in_packet[i*DW +: DW] = pkts[i];
   endtask

   task automatic do_reset;
      out_ready = 1'b0;
      in_valid  = '0;
      rst       = 1'b1;
      exp_q.delete();
      #3;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      rst = 1'b1;
      in_valid = '1;
      out_ready = 1'b1;
      for (int i = 0; i < NI; i++) pkts[i] = 32'hDEAD_0000 + DW'(i);
      pack_pkts();
      #2;
      checks++; if (in_ready !== 5'b0)   begin errors++; $display("FAIL reset_in_ready: got %b, expected 00000", in_ready); end
      checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
      checks++; if (out_packet !== '0)   begin errors++; $display("FAIL reset_out_packet: got %h, expected 0", out_packet); end
      checks++; if (occupancy !== 3'd0)  begin errors++; $display("FAIL reset_occupancy: got %0d, expected 0", occupancy); end
      checks++; if (tx_count !== 16'd0)  begin errors++; $display("FAIL reset_tx_count: got %0d, expected 0", tx_count); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready !== 5'b0)   begin errors++; $display("FAIL reset_clocked_in_ready: got %b, expected 00000", in_ready); end
      checks++; if (occupancy !== 3'd0)  begin errors++; $display("FAIL reset_clocked_occupancy: got %0d, expected 0", occupancy); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = '0;
      out_ready = 1'b0;
   endtask

   task automatic test_fairness;
      int gcnt [NI];
      logic [NI-1:0] exp_r;
      for (int i = 0; i < NI; i++) gcnt[i] = 0;
      for (int c = 0; c < 10; c++) begin
         for (int i = 0; i < NI; i++) pkts[i] = {8'(i + 1), 8'h00, 16'(c)};
         pack_pkts();
         in_valid = 5'b11111;
         out_ready = 1'b1;
         @(negedge clk);
         exp_r = 5'(1 << (c % NI));
         checks++;
         if (in_ready !== exp_r) begin
            errors++;
            $display("FAIL fairness_grant cycle %0d: got %b, expected %b", c, in_ready, exp_r);
         end
         for (int i = 0; i < NI; i++) if (in_ready[i]) gcnt[i]++;
         exp_q.push_back(pkts[c % NI]);
         tick();
      end
      in_valid = '0;
      tick();
      tick();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (gcnt[i] != 2) begin
            errors++;
            $display("FAIL fairness_count input %0d: got %0d grants, expected 2", i, gcnt[i]);
         end
      end
      @(negedge clk);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fairness_drain: %0d packets missing, expected 0", exp_q.size()); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fairness_occupancy: got %0d, expected 0", occupancy); end
      out_ready = 1'b0;
      tick();
   endtask

   task automatic test_single;
      do_reset();
      pkts[2] = 32'hA5A5_0001;
      pack_pkts();
      in_valid = 5'b00100;
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 5'b00100) begin errors++; $display("FAIL single_in_ready: got %b, expected 00100", in_ready); end
      checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL single_no_bypass: got out_valid %b, expected 0", out_valid); end
      exp_q.push_back(pkts[2]);
      tick();
      in_valid = '0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1)           begin errors++; $display("FAIL single_latency_valid: got %b, expected 1", out_valid); end
      checks++; if (out_packet !== 32'hA5A5_0001) begin errors++; $display("FAIL single_latency_packet: got %h, expected a5a50001", out_packet); end
      checks++; if (occupancy !== 3'd1)           begin errors++; $display("FAIL single_occupancy: got %0d, expected 1", occupancy); end
      tick();
      @(negedge clk);
      checks++; if (tx_count !== 16'd1)  begin errors++; $display("FAIL single_tx_count: got %0d, expected 1", tx_count); end
      checks++; if (occupancy !== 3'd0)  begin errors++; $display("FAIL single_drained: got %0d, expected 0", occupancy); end
      checks++; if (out_packet !== '0)   begin errors++; $display("FAIL single_empty_packet: got %h, expected 0", out_packet); end
      tick();
      @(negedge clk);
      checks++; if (tx_count !== 16'd1)  begin errors++; $display("FAIL single_ready_when_empty: got tx_count %0d, expected 1", tx_count); end
      out_ready = 1'b0;
      tick();
   endtask

   task automatic test_full;
      in_valid = 5'b00001;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         pkts[0] = 32'hF000_0000 + DW'(c);
         pack_pkts();
         @(negedge clk);
         checks++;
         if (in_ready !== ((c < 4) ? 5'b00001 : 5'b00000)) begin
            errors++;
            $display("FAIL full_fill_ready cycle %0d: got %b, expected %b", c, in_ready, (c < 4) ? 5'b00001 : 5'b00000);
         end
         if (c < 4) exp_q.push_back(pkts[0]);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 5'b0)  begin errors++; $display("FAIL full_pop_no_bypass: got %b, expected 00000", in_ready); end
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occupancy: got %0d, expected 4", occupancy); end
      tick();
      out_ready = 1'b0;
      pkts[0] = 32'hF000_0010;
      pack_pkts();
      @(negedge clk);
      checks++; if (in_ready !== 5'b00001) begin errors++; $display("FAIL full_refill_ready: got %b, expected 00001", in_ready); end
      checks++; if (occupancy !== 3'd3)    begin errors++; $display("FAIL full_after_pop: got %0d, expected 3", occupancy); end
      exp_q.push_back(pkts[0]);
      tick();
      in_valid = '0;
      @(negedge clk);
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_refilled: got %0d, expected 4", occupancy); end
      tick();
      out_ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d, expected 0", occupancy); end
      checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL full_drain_queue: %0d packets missing, expected 0", exp_q.size()); end
      out_ready = 1'b0;
      tick();
   endtask

   task automatic test_backpressure;
      logic [DW-1:0] p1;
      logic [DW-1:0] p2;
      logic [4:0]    rdy_seq;
      logic [DW-1:0] want [5];
      p1 = 32'h1111_0001;
      p2 = 32'h2222_0002;
      rdy_seq = 5'b10100;
      want[0] = p1; want[1] = p1; want[2] = p1; want[3] = p2; want[4] = p2;
      in_valid = 5'b00010;
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         pkts[1] = (k == 0) ? p1 : p2;
         pack_pkts();
         @(negedge clk);
         checks++; if (in_ready !== 5'b00010) begin errors++; $display("FAIL bp_load_ready %0d: got %b, expected 00010", k, in_ready); end
         exp_q.push_back(pkts[1]);
         tick();
      end
      in_valid = '0;
      for (int k = 0; k < 5; k++) begin
         out_ready = rdy_seq[k];
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_packet !== want[k]) begin
            errors++;
            $display("FAIL bp_hold step %0d: got valid %b packet %h, expected valid 1 packet %h", k, out_valid, out_packet, want[k]);
         end
         tick();
      end
      out_ready = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got out_valid %b, expected 0", out_valid); end
      checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL bp_queue: %0d packets missing, expected 0", exp_q.size()); end
      tick();
   endtask

   task automatic test_push_pop;
      do_reset();
      in_valid = 5'b10000;
      for (int k = 0; k < 2; k++) begin
         pkts[4] = 32'hC000_0000 + DW'(k);
         pack_pkts();
         exp_q.push_back(pkts[4]);
         tick();
      end
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         pkts[4] = 32'hC000_0002 + DW'(c);
         pack_pkts();
         @(negedge clk);
         checks++;
         if (in_ready !== 5'b10000 || occupancy !== 3'd2 || tx_count !== 16'(c)) begin
            errors++;
            $display("FAIL push_pop cycle %0d: got ready %b occ %0d tx %0d, expected ready 10000 occ 2 tx %0d",
                     c, in_ready, occupancy, tx_count, c);
         end
         exp_q.push_back(pkts[4]);
         tick();
      end
      in_valid = '0;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (occupancy !== 3'd0 || tx_count !== 16'd8 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL push_pop_drain: got occ %0d tx %0d queue %0d, expected occ 0 tx 8 queue 0", occupancy, tx_count, exp_q.size());
      end
      out_ready = 1'b0;
      tick();
   endtask

   task automatic test_async_reset;
      in_valid = 5'b00001;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         pkts[0] = 32'hD000_0000 + DW'(k);
         pack_pkts();
         exp_q.push_back(pkts[0]);
         tick();
      end
      in_valid = '0;
      @(negedge clk);
      checks++;
      if (occupancy !== 3'd3 || tx_count !== 16'd8 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: got occ %0d tx %0d valid %b, expected occ 3 tx 8 valid 1", occupancy, tx_count, out_valid);
      end
      #2;
      rst = 1'b1;
      in_valid = '1;
      exp_q.delete();
      #1;
      checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL async_out_valid: got %b, expected 0", out_valid); end
      checks++; if (occupancy !== 3'd0)  begin errors++; $display("FAIL async_occupancy: got %0d, expected 0", occupancy); end
      checks++; if (tx_count !== 16'd0)  begin errors++; $display("FAIL async_tx_count: got %0d, expected 0", tx_count); end
      checks++; if (out_packet !== '0)   begin errors++; $display("FAIL async_out_packet: got %h, expected 0", out_packet); end
      checks++; if (in_ready !== 5'b0)   begin errors++; $display("FAIL async_in_ready: got %b, expected 00000", in_ready); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = '0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL async_after: got valid %b occ %0d, expected 0 0", out_valid, occupancy); end
      tick();
   endtask

   task automatic test_random_arb;
      int model_ptr;
      int model_occ;
      int g;
      int idx;
      logic [NI-1:0] exp_r;
      do_reset();
      model_ptr = 0;
      model_occ = 0;
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NI; i++) pkts[i] = $urandom;
         pack_pkts();
         in_valid = 5'($urandom_range(0, 31));
         out_ready = ($urandom_range(0, 2) == 0);
         @(negedge clk);
         g = -1;
         if (model_occ < 4) begin
            for (int k = 0; k < NI; k++) begin
               idx = (model_ptr + k) % NI;
               if (g < 0 && in_valid[idx]) g = idx;
            end
         end
         exp_r = '0;
         if (g >= 0) exp_r[g] = 1'b1;
         checks++;
         if (in_ready !== exp_r || occupancy !== 3'(model_occ) || out_valid !== (model_occ != 0)) begin
            errors++;
            $display("FAIL random cycle %0d: got ready %b occ %0d valid %b, expected ready %b occ %0d valid %b",
                     c, in_ready, occupancy, out_valid, exp_r, model_occ, model_occ != 0);
         end
         if (model_occ != 0 && out_ready) model_occ--;
         if (g >= 0) begin
            exp_q.push_back(pkts[g]);
            model_ptr = (g + 1) % NI;
            model_occ++;
         end
         tick();
      end
      in_valid = '0;
      out_ready = 1'b1;
      repeat (5) tick();
      @(negedge clk);
      checks++; if (exp_q.size() != 0 || occupancy !== 3'd0) begin errors++; $display("FAIL random_drain: got queue %0d occ %0d, expected 0 0", exp_q.size(), occupancy); end
      out_ready = 1'b0;
      tick();
   endtask

   task automatic test_wrap;
      do_reset();
      in_valid = 5'b00001;
      out_ready = 1'b1;
      for (int c = 0; c < 65536; c++) begin
         pkts[0] = DW'(c);
         pack_pkts();
         exp_q.push_back(pkts[0]);
         tick();
      end
      in_valid = '0;
      @(negedge clk);
      checks++; if (tx_count !== 16'hFFFF || occupancy !== 3'd1) begin errors++; $display("FAIL wrap_pre: got tx %h occ %0d, expected tx ffff occ 1", tx_count, occupancy); end
      tick();
      @(negedge clk);
      checks++; if (tx_count !== 16'h0000) begin errors++; $display("FAIL wrap_tx_count: got %h, expected 0000", tx_count); end
      checks++; if (occupancy !== 3'd0 || exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: got occ %0d queue %0d, expected 0 0", occupancy, exp_q.size()); end
      out_ready = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < NI; i++) pkts[i] = '0;
      test_reset();
      test_fairness();
      test_single();
      test_full();
      test_backpressure();
      test_push_pop();
      test_async_reset();
      test_random_arb();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
